add_n_pipe: RTL and testbench

- Pipelined, parametrised N-input unsigned adder tree with valid/ready handshakes on input and output.
- Successor to the single-cycle add_N block: configurable operand width and element count, registered tree levels, full-precision sum, and wrap/saturate narrow output with overflow flag.
- Sits between a packed-vector producer and any downstream consumer that can apply backpressure.

---
 rtl/add_n_pipe.sv | 104 ++++++++++
 tb/tb_add_n_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/add_n_pipe.sv
// Pipelined N-input unsigned adder tree with valid/ready handshakes.
// Exact SUM_WIDTH sum plus a narrow wrap/saturate result and overflow flag.
module add_n_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 4,
  parameter int SATURATE   = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]              inps,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [DATA_WIDTH+$clog2(NUM_ELEMS)-1:0]      sum,
  output logic [DATA_WIDTH-1:0]                        outp,
  output logic                                         ovf
);

  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_ELEMS);
  localparam int LEVELS    = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  // Number of partials entering a given tree level; an odd count rounds up.
  function automatic int countIn(input int level);
    int c = NUM_ELEMS;
    for (int i = 0; i < level; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  logic [SUM_WIDTH-1:0] lvl_q [LEVELS][NUM_ELEMS];
  logic [SUM_WIDTH-1:0] lvl_d [LEVELS][NUM_ELEMS];
  logic [SUM_WIDTH-1:0] src   [LEVELS][NUM_ELEMS];
  logic [LEVELS-1:0]    valid_q;
  logic [LEVELS-1:0]    valid_d;
  logic                 advance;

  assign out_valid = valid_q[LEVELS-1];
  assign advance   = out_ready || !out_valid;
  assign in_ready  = advance;

  // Every partial is SUM_WIDTH wide, so no level can overflow. Summing
  // element i into slot i/2 pairs neighbours and lets an odd leftover pass.
  always_comb begin
    for (int k = 0; k < LEVELS; k++) begin
      for (int j = 0; j < NUM_ELEMS; j++) begin
        src[k][j]   = '0;
        lvl_d[k][j] = '0;
      end
    end
    for (int j = 0; j < NUM_ELEMS; j++) begin
      src[0][j] = SUM_WIDTH'(inps[j*DATA_WIDTH +: DATA_WIDTH]);
    end
    for (int k = 1; k < LEVELS; k++) begin
      for (int j = 0; j < NUM_ELEMS; j++) begin
        src[k][j] = lvl_q[k-1][j];
      end
    end
    for (int k = 0; k < LEVELS; k++) begin
      for (int i = 0; i < countIn(k); i++) begin
        lvl_d[k][i/2] = lvl_d[k][i/2] + src[k][i];
      end
    end
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid && in_ready;
    for (int k = 1; k < LEVELS; k++) begin
      valid_d[k] = valid_q[k-1];
    end
  end

  // The whole pipe moves as one; empty slots shift along like data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        for (int j = 0; j < NUM_ELEMS; j++) begin
          lvl_q[k][j] <= '0;
        end
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int k = 0; k < LEVELS; k++) begin
        for (int j = 0; j < NUM_ELEMS; j++) begin
          lvl_q[k][j] <= lvl_d[k][j];
        end
      end
    end
  end

  assign sum = lvl_q[LEVELS-1][0];

  if (SUM_WIDTH > DATA_WIDTH) begin : g_ovf
    assign ovf = |sum[SUM_WIDTH-1:DATA_WIDTH];
  end else begin : g_no_ovf
    assign ovf = 1'b0;
  end

  assign outp = ((SATURATE != 0) && ovf) ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_add_n_pipe.sv
// Directed bench for add_n_pipe across several tree shapes, covering
// backpressure, full-rate streaming and asynchronous reset.
module tb_add_n_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Instance A: DW=8, N=4, saturating
  logic        aValid, aReady, aOutValid, aOutReady, aOvf;
  logic [31:0] aInps;
  logic [9:0]  aSum;
  logic [7:0]  aOutp;
  // Instance B: DW=2, N=2, wrapping
  logic        bValid, bReady, bOutValid, bOvf;
  logic [3:0]  bInps;
  logic [2:0]  bSum;
  logic [1:0]  bOutp;
  // Instance C: DW=4, N=5, wrapping (odd passthrough)
  logic        cValid, cReady, cOutValid, cOvf;
  logic [19:0] cInps;
  logic [6:0]  cSum;
  logic [3:0]  cOutp;
  // Instance D: DW=8, N=1
  logic        dValid, dReady, dOutValid, dOvf;
  logic [7:0]  dInps, dSum, dOutp;

  add_n_pipe #(.DATA_WIDTH(8), .NUM_ELEMS(4), .SATURATE(1)) dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(aValid), .in_ready(aReady), .inps(aInps),
    .out_valid(aOutValid), .out_ready(aOutReady), .sum(aSum), .outp(aOutp), .ovf(aOvf));
  add_n_pipe #(.DATA_WIDTH(2), .NUM_ELEMS(2), .SATURATE(0)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(bValid), .in_ready(bReady), .inps(bInps),
    .out_valid(bOutValid), .out_ready(1'b1), .sum(bSum), .outp(bOutp), .ovf(bOvf));
  add_n_pipe #(.DATA_WIDTH(4), .NUM_ELEMS(5), .SATURATE(0)) dutC (
    .clk(clk), .rst_n(rst_n), .in_valid(cValid), .in_ready(cReady), .inps(cInps),
    .out_valid(cOutValid), .out_ready(1'b1), .sum(cSum), .outp(cOutp), .ovf(cOvf));
  add_n_pipe #(.DATA_WIDTH(8), .NUM_ELEMS(1), .SATURATE(0)) dutD (
    .clk(clk), .rst_n(rst_n), .in_valid(dValid), .in_ready(dReady), .inps(dInps),
    .out_valid(dOutValid), .out_ready(1'b1), .sum(dSum), .outp(dOutp), .ovf(dOvf));

  function automatic int refSum4(input logic [31:0] v);
    return int'(v[7:0]) + int'(v[15:8]) + int'(v[23:16]) + int'(v[31:24]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] vec, input logic ready);
    aValid    = valid;
    aInps     = vec;
    aOutReady = ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bpVec [8];
  logic [31:0] tpVec [20];
  int          tpExp [20];
  int          sent;
  int          got;

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1);
    bValid = 1'b0; bInps = '0;
    cValid = 1'b0; cInps = '0;
    dValid = 1'b0; dInps = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", aOutValid, 0);
    checkOutput("reset_sum", aSum, 0);
    checkOutput("reset_outp", aOutp, 0);
    checkOutput("reset_ovf", aOvf, 0);
    checkOutput("reset_c_valid", cOutValid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", aReady, 1);
    nextCycle();

    // DW=2, N=2: 3+3 = 6 wraps to 2
    bValid = 1'b1; bInps = {2'd3, 2'd3};
    nextCycle();
    bValid = 1'b0;
    checkOutput("b_valid", bOutValid, 1);
    checkOutput("b_sum", bSum, 6);
    checkOutput("b_outp", bOutp, 2);
    checkOutput("b_ovf", bOvf, 1);
    nextCycle();
    checkOutput("b_drained", bOutValid, 0);

    // DW=8, N=4 saturating: back-to-back vectors, two-cycle latency
    applyStimulus(1'b1, {8'd10, 8'd50, 8'd100, 8'd200}, 1'b1);
    nextCycle();
    checkOutput("a_lat_not_yet", aOutValid, 0);
    applyStimulus(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("a_sat_valid", aOutValid, 1);
    checkOutput("a_sat_sum", aSum, 360);
    checkOutput("a_sat_outp", aOutp, 255);
    checkOutput("a_sat_ovf", aOvf, 1);
    nextCycle();
    checkOutput("a_small_valid", aOutValid, 1);
    checkOutput("a_small_sum", aSum, 10);
    checkOutput("a_small_outp", aOutp, 10);
    checkOutput("a_small_ovf", aOvf, 0);
    nextCycle();
    checkOutput("a_drained", aOutValid, 0);

    // DW=4, N=5: three levels, 75 wraps to 11
    cValid = 1'b1; cInps = {5{4'd15}};
    nextCycle();
    cValid = 1'b0;
    nextCycle();
    checkOutput("c_lat_not_yet", cOutValid, 0);
    nextCycle();
    checkOutput("c_valid", cOutValid, 1);
    checkOutput("c_sum", cSum, 75);
    checkOutput("c_outp", cOutp, 11);
    checkOutput("c_ovf", cOvf, 1);

    // N=1: single stage, value passes straight through
    dValid = 1'b1; dInps = 8'd77;
    nextCycle();
    dValid = 1'b0;
    checkOutput("d_valid", dOutValid, 1);
    checkOutput("d_sum", dSum, 77);
    checkOutput("d_ovf", dOvf, 0);
    nextCycle();

    // Backpressure: out_ready low for cycles 3..6 of an 8-vector stream
    for (int i = 0; i < 8; i++) begin
      bpVec[i] = {8'(i * 3), 8'(i + 40), 8'(250 - i), 8'(i * 17)};
    end
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      applyStimulus(sent < 8, bpVec[sent % 8], !(c >= 3 && c <= 6));
      #1;
      if (c >= 3 && c <= 6) begin
        checkOutput("bp_in_ready_stall", aReady, 0);
        checkOutput("bp_valid_stall", aOutValid, 1);
        checkOutput("bp_stable_sum", aSum, refSum4(bpVec[1]));
      end
      if (aOutValid && aOutReady) begin
        checkOutput("bp_order", aSum, refSum4(bpVec[got % 8]));
        got++;
      end
      if (aValid && aReady) sent++;
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_received", got, 8);
    checkOutput("bp_sent", sent, 8);
    nextCycle();
    nextCycle();

    // Full throughput: 20 random vectors, outputs exactly two cycles later
    for (int i = 0; i < 20; i++) begin
      tpVec[i] = $urandom;
      tpExp[i] = refSum4(tpVec[i]);
    end
    for (int c = 0; c < 23; c++) begin
      applyStimulus(c < 20, tpVec[c % 20], 1'b1);
      #1;
      if (c < 2 || c >= 22) begin
        checkOutput("tp_idle", aOutValid, 0);
      end else begin
        checkOutput("tp_valid", aOutValid, 1);
        checkOutput("tp_sum", aSum, tpExp[c - 2]);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b1);

    // Async reset with two vectors in flight
    applyStimulus(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    nextCycle();
    applyStimulus(1'b1, {8'd9, 8'd9, 8'd9, 8'd9}, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("rst_pre_valid", aOutValid, 1);
    checkOutput("rst_pre_sum", aSum, 10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", aOutValid, 0);
    checkOutput("rst_async_sum", aSum, 0);
    nextCycle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_in_ready", aReady, 1);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput("rst_no_stale", aOutValid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
